// File: rtl/student_iis_pkg.sv
// Shared types for the codec-side I2S slave: FSM states, channel tags and the
// fixed one-bit I2S data delay after each LRCLK edge.
package student_iis_pkg;
  typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, PAD} iis_slave_state_e;
  typedef enum logic {CH_LEFT, CH_RIGHT} iis_chan_e;
  localparam int I2S_DELAY_BITS = 1;
endpackage

// File: rtl/student_iis_edge_sync.sv
// Two-flop synchroniser for one asynchronous input, plus one extra flop so that
// rise/fall pulses line up with the synchronised level.
module student_iis_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign q_o    = sync_q[1];
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];
endmodule

// File: rtl/student_iis_codec_slave.sv
// Codec-side I2S slave: follows external BCLK/LRCLK, deserialises DAC data into
// L/R word pairs and serialises locally supplied L/R samples onto ADC data.
module student_iis_codec_slave
  import student_iis_pkg::*;
#(
  parameter int DATA_SIZE_RX = 24,
  parameter int DATA_SIZE_TX = 16,
  parameter int SLOT_BITS    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    AC_BCLK,
  input  logic                    AC_LRCLK,
  input  logic                    AC_DAC_SDATA,
  output logic                    AC_ADC_SDATA,
  input  logic [DATA_SIZE_TX-1:0] tx_left_i,
  input  logic [DATA_SIZE_TX-1:0] tx_right_i,
  output logic [DATA_SIZE_RX-1:0] rx_left_o,
  output logic [DATA_SIZE_RX-1:0] rx_right_o,
  output logic                    rx_valid_o,
  output logic                    frame_err_o
);
  localparam int CNT_W    = $clog2(SLOT_BITS);
  localparam int MAX_BITS = (DATA_SIZE_RX > DATA_SIZE_TX) ? DATA_SIZE_RX : DATA_SIZE_TX;
  localparam logic [CNT_W-1:0] RX_LIM  = CNT_W'(DATA_SIZE_RX);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_SIZE_RX - 1);
  localparam logic [CNT_W-1:0] TX_LIM  = CNT_W'(DATA_SIZE_TX);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(MAX_BITS - 1);
  localparam logic [CNT_W-1:0] SAT     = CNT_W'(SLOT_BITS - 1);

  // Bit 0: BCLK, bit 1: LRCLK, bit 2: DAC data -- identical latency keeps data aligned to bclk_rise.
  logic [2:0] raw, sync, rise, fall;
  logic       sync_unused;
  assign raw = {AC_DAC_SDATA, AC_LRCLK, AC_BCLK};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    student_iis_edge_sync u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (raw[g]),
      .q_o   (sync[g]),
      .rise_o(rise[g]),
      .fall_o(fall[g])
    );
  end
  assign sync_unused = ^{sync[0], rise[2], fall[2]};

  logic bclk_rise, bclk_fall, lr_q, lr_edge, lr_fall, dac;
  assign bclk_rise = rise[0];
  assign bclk_fall = fall[0];
  assign lr_q      = sync[1];
  assign lr_fall   = fall[1];
  assign lr_edge   = rise[1] | fall[1];
  assign dac       = sync[2];

  iis_slave_state_e         state_q, state_d;
  iis_chan_e                chan_q, chan_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_SIZE_RX-1:0]  rx_sr_q, rx_sr_d, stage_q, stage_d, rx_word;
  logic [DATA_SIZE_RX-1:0]  rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic                     stage_ok_q, stage_ok_d;
  logic [DATA_SIZE_TX-1:0]  tx_l_q, tx_l_d, tx_r_q, tx_r_d, tx_sr_q, tx_sr_d;
  logic                     adc_q, adc_d, valid_q, valid_d, err_q, err_d;

  assign rx_word = {rx_sr_q[DATA_SIZE_RX-2:0], dac};

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    rx_sr_d    = rx_sr_q;
    stage_d    = stage_q;
    stage_ok_d = stage_ok_q;
    rx_l_d     = rx_l_q;
    rx_r_d     = rx_r_q;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    tx_sr_d    = tx_sr_q;
    adc_d      = adc_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (state_q == ALIGN) begin
      adc_d = 1'b0;
      if (lr_fall) begin
        state_d = DELAY;
        chan_d  = CH_LEFT;
        tx_l_d  = tx_left_i;
        tx_r_d  = tx_right_i;
      end
    end else if (lr_edge) begin
      // A new slot always wins, even over a coincident bclk_rise (that rise is the delay bit).
      if (state_q == SHIFT && cnt_q < RX_LIM) begin
        err_d      = 1'b1;
        stage_ok_d = 1'b0;
      end
      state_d = DELAY;
      chan_d  = lr_q ? CH_RIGHT : CH_LEFT;
      cnt_d   = '0;
      adc_d   = 1'b0;
      if (lr_fall) begin
        tx_l_d = tx_left_i;
        tx_r_d = tx_right_i;
      end
    end else if (state_q == DELAY) begin
      adc_d = 1'b0;
      if (bclk_rise) begin
        state_d = SHIFT;
        cnt_d   = '0;
        tx_sr_d = (chan_q == CH_LEFT) ? tx_l_q : tx_r_q;
      end
    end else if (state_q == SHIFT) begin
      if (bclk_fall) begin
        adc_d   = (cnt_q < TX_LIM) && tx_sr_q[DATA_SIZE_TX-1];
        tx_sr_d = tx_sr_q << 1;
      end
      if (bclk_rise) begin
        if (cnt_q < RX_LIM) rx_sr_d = rx_word;
        if (cnt_q == RX_LAST) begin
          if (chan_q == CH_LEFT) begin
            stage_d    = rx_word;
            stage_ok_d = 1'b1;
          end else begin
            if (stage_ok_q) begin
              rx_l_d  = stage_q;
              rx_r_d  = rx_word;
              valid_d = 1'b1;
            end
            stage_ok_d = 1'b0;
          end
        end
        if (cnt_q == LAST) state_d = PAD;
        if (cnt_q != SAT)  cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      adc_d = 1'b0;
      if (bclk_rise && cnt_q != SAT) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ALIGN;
      chan_q     <= CH_LEFT;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      stage_q    <= '0;
      stage_ok_q <= 1'b0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      tx_sr_q    <= '0;
      adc_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      rx_sr_q    <= rx_sr_d;
      stage_q    <= stage_d;
      stage_ok_q <= stage_ok_d;
      rx_l_q     <= rx_l_d;
      rx_r_q     <= rx_r_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      tx_sr_q    <= tx_sr_d;
      adc_q      <= adc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign AC_ADC_SDATA = adc_q;
  assign rx_left_o    = rx_l_q;
  assign rx_right_o   = rx_r_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = err_q;
endmodule

// File: tb/tb_student_iis_codec_slave.sv
// Bench acting as the I2S master: drives BCLK/LRCLK/DAC frames, predicts RX pairs,
// frame errors and ADC words, and checks them from independent monitors.
module tb_student_iis_codec_slave;
  typedef struct {
    bit          chk;
    logic [15:0] w;
  } tx_exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        AC_BCLK = 1'b1;
  logic        AC_LRCLK = 1'b1;
  logic        AC_DAC_SDATA = 1'b0;
  logic        AC_ADC_SDATA;
  logic [15:0] tx_left_i = 16'h0;
  logic [15:0] tx_right_i = 16'h0;
  logic [23:0] rx_left_o, rx_right_o;
  logic        rx_valid_o, frame_err_o;

  int          vectors = 0;
  int          errors = 0;
  logic [47:0] rxq[$];
  bit          errq[$];
  tx_exp_t     txq[$];

  always #5 clk = ~clk;

  student_iis_codec_slave dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .AC_BCLK     (AC_BCLK),
    .AC_LRCLK    (AC_LRCLK),
    .AC_DAC_SDATA(AC_DAC_SDATA),
    .AC_ADC_SDATA(AC_ADC_SDATA),
    .tx_left_i   (tx_left_i),
    .tx_right_i  (tx_right_i),
    .rx_left_o   (rx_left_o),
    .rx_right_o  (rx_right_o),
    .rx_valid_o  (rx_valid_o),
    .frame_err_o (frame_err_o)
  );

  task automatic check_zero(input string nm);
    vectors++;
    if ({rx_left_o, rx_right_o, rx_valid_o, frame_err_o, AC_ADC_SDATA} !== '0) begin
      errors++;
      $display("FAIL %s: got L=%h R=%h v=%b err=%b adc=%b, required all 0",
               nm, rx_left_o, rx_right_o, rx_valid_o, frame_err_o, AC_ADC_SDATA);
    end
  endtask

  // One BCLK period, 8 clk low then 8 clk high; optional 3-cycle reset in the low half.
  task automatic bit_period(input logic lr, input logic d, input bit do_rst);
    @(negedge clk);
    AC_BCLK = 1'b0; AC_LRCLK = lr; AC_DAC_SDATA = d;
    if (do_rst) begin
      rst_i = 1'b1;
      @(negedge clk);
      check_zero("mid_frame_reset");
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    AC_BCLK = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic slot(input logic lr, input logic [23:0] d, input int nbits, input int rst_at,
                      input bit chk, input logic [15:0] txw, input bit chg,
                      input logic [15:0] nl, input logic [15:0] nr);
    logic b;
    txq.push_back('{chk, txw});
    for (int k = 0; k < nbits; k++) begin
      if (chg && k == 16) begin
        tx_left_i  = nl;
        tx_right_i = nr;
      end
      b = (k >= 1 && k <= 24) ? d[24-k] : 1'b0;
      bit_period(lr, b, k == rst_at);
    end
  endtask

  // Full L+R frame; a short left slot models an early LRCLK toggle.
  task automatic frame(input logic [23:0] l, input logic [23:0] r, input int lbits,
                       input int rst_at, input logic [15:0] nl, input logic [15:0] nr);
    logic [15:0] el, er;
    bit ok;
    el = tx_left_i;
    er = tx_right_i;
    ok = (lbits == 32);
    if (!ok) errq.push_back(1'b1);
    if (ok && rst_at < 0) rxq.push_back({l, r});
    slot(1'b0, l, lbits, -1, ok, el, 1'b1, nl, nr);
    slot(1'b1, r, 32, rst_at, ok && rst_at < 0, er, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin : rx_mon
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid_o) begin
        vectors++;
        if (rxq.size() == 0) begin
          errors++;
          $display("FAIL rx_pair: unexpected rx_valid_o with L=%h R=%h, required none", rx_left_o, rx_right_o);
        end else begin
          e = rxq.pop_front();
          if ({rx_left_o, rx_right_o} !== e) begin
            errors++;
            $display("FAIL rx_pair: got L=%h R=%h, required L=%h R=%h", rx_left_o, rx_right_o, e[47:24], e[23:0]);
          end
        end
      end
      if (frame_err_o) begin
        vectors++;
        if (errq.size() == 0) begin
          errors++;
          $display("FAIL frame_err: unexpected pulse, required none");
        end else begin
          void'(errq.pop_front());
        end
      end
    end
  end

  initial begin : tx_mon
    logic        last_lr;
    bit          started;
    int          k;
    logic [15:0] w;
    logic        pad;
    tx_exp_t     e;
    last_lr = 1'b0; started = 1'b0; k = 0; w = '0; pad = 1'b0;
    @(negedge AC_BCLK);
    forever begin
      @(posedge AC_BCLK);
      if (AC_LRCLK !== last_lr) begin
        if (started && txq.size() > 0) begin
          e = txq.pop_front();
          if (e.chk) begin
            vectors++;
            if (w !== e.w || pad !== 1'b0) begin
              errors++;
              $display("FAIL adc_word: got %h pad_bits_set=%b, required %h pad 0", w, pad, e.w);
            end
          end
        end
        started = 1'b1; k = 0; w = '0; pad = 1'b0; last_lr = AC_LRCLK;
      end
      if (k >= 1 && k <= 16) w = {w[14:0], AC_ADC_SDATA};
      else                   pad = pad | AC_ADC_SDATA;
      k++;
    end
  end

  initial begin : stim
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    @(negedge clk);
    rst_i = 1'b0;
    tx_left_i  = 16'h8001;
    tx_right_i = 16'h7FFE;
    // Released with LRCLK high: slave must sit in ALIGN with ADC low.
    slot(1'b1, 24'($urandom), 20, -1, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0);
    frame(24'hA5A5A5, 24'h00F00F, 32, -1, 16'h1111, 16'hEEEE);
    frame(24'($urandom), 24'($urandom), 32, -1, 16'h2222, 16'hDDDD);
    frame(24'($urandom), 24'($urandom), 32, -1, 16'h2222, 16'hDDDD);
    frame(24'($urandom), 24'($urandom), 11, -1, 16'h0, 16'h0);
    frame(24'($urandom), 24'($urandom), 32, -1, 16'h1234, 16'h5678);
    frame(24'($urandom), 24'($urandom), 32, 5, 16'h0F0F, 16'hF0F0);
    repeat (16) frame(24'($urandom), 24'($urandom), 32, -1, 16'($urandom), 16'($urandom));
    slot(1'b0, 24'h0, 4, -1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    repeat (40) @(negedge clk);
    vectors++;
    if (rxq.size() != 0) begin
      errors++;
      $display("FAIL rx_pending: %0d pairs never delivered, required 0", rxq.size());
    end
    vectors++;
    if (errq.size() != 0) begin
      errors++;
      $display("FAIL err_pending: %0d frame_err pulses missing, required 0", errq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
